// File: rtl/axi_slave_mem.sv
// Single-beat AXI slave backed by a DEPTH x 32-bit register memory.
// Independent write (AW/W/B) and read (AR/R) FSMs; every output comes straight from a flop.
module axi_slave_mem #(
    parameter int DEPTH = 16
) (
    input  logic        ACLK,
    input  logic        ARESET,
    input  logic        AWVALID,
    output logic        AWREADY,
    input  logic [31:0] AWADDR,
    input  logic [3:0]  AWID,
    input  logic        WVALID,
    output logic        WREADY,
    input  logic [31:0] WDATA,
    input  logic        WLAST,
    output logic        BVALID,
    input  logic        BREADY,
    output logic [1:0]  BRESP,
    output logic [3:0]  BID,
    input  logic        ARVALID,
    output logic        ARREADY,
    input  logic [31:0] ARADDR,
    input  logic [3:0]  ARID,
    output logic        RVALID,
    input  logic        RREADY,
    output logic [31:0] RDATA,
    output logic        RLAST,
    output logic [3:0]  RID
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [1:0] W_IDLE     = 2'd0;
    localparam logic [1:0] W_GOT_ADDR = 2'd1;
    localparam logic [1:0] W_GOT_DATA = 2'd2;
    localparam logic [1:0] W_RESP     = 2'd3;

    localparam logic [0:0] R_IDLE = 1'b0;
    localparam logic [0:0] R_DATA = 1'b1;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    function automatic logic in_range(input logic [31:0] a);
        return (a >> (AW + 2)) == 32'd0;
    endfunction

    // Byte-offset bits are intentionally ignored.
    logic unused_addr_lsbs;
    assign unused_addr_lsbs = ^{AWADDR[1:0], ARADDR[1:0]};

    logic [31:0] mem_q [DEPTH];

    // ---------------- write path ----------------
    logic [1:0]  w_state_q, w_state_d;
    logic        awready_q, wready_q;
    logic [31:0] awaddr_q, wdata_q;
    logic [3:0]  awid_q;
    logic        wlast_q;
    logic        bvalid_q;
    logic [1:0]  bresp_q;
    logic [3:0]  bid_q;

    logic        aw_hs, w_hs, enter_resp, wr_ok;
    logic [31:0] eff_addr, eff_data;
    logic [3:0]  eff_id;
    logic        eff_last;

    assign aw_hs = AWVALID && awready_q;
    assign w_hs  = WVALID && wready_q;

    always_comb begin
        w_state_d = w_state_q;
        case (w_state_q)
            W_IDLE: begin
                if (aw_hs && w_hs) w_state_d = W_RESP;
                else if (aw_hs)    w_state_d = W_GOT_ADDR;
                else if (w_hs)     w_state_d = W_GOT_DATA;
            end
            W_GOT_ADDR: if (w_hs)  w_state_d = W_RESP;
            W_GOT_DATA: if (aw_hs) w_state_d = W_RESP;
            W_RESP:     if (BREADY && bvalid_q) w_state_d = W_IDLE;
            default:    w_state_d = W_IDLE;
        endcase
    end

    // Whichever half arrives on the completing edge is taken from the bus, the other from its capture flop.
    assign eff_addr   = aw_hs ? AWADDR : awaddr_q;
    assign eff_id     = aw_hs ? AWID   : awid_q;
    assign eff_data   = w_hs  ? WDATA  : wdata_q;
    assign eff_last   = w_hs  ? WLAST  : wlast_q;
    assign enter_resp = (w_state_d == W_RESP) && (w_state_q != W_RESP);
    assign wr_ok      = enter_resp && in_range(eff_addr) && eff_last;

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            w_state_q <= W_IDLE;
            awready_q <= 1'b0;
            wready_q  <= 1'b0;
            awaddr_q  <= '0;
            awid_q    <= '0;
            wdata_q   <= '0;
            wlast_q   <= 1'b0;
            bvalid_q  <= 1'b0;
            bresp_q   <= '0;
            bid_q     <= '0;
        end else begin
            w_state_q <= w_state_d;
            // Readies track the next state, so they come up one edge after reset release.
            awready_q <= (w_state_d == W_IDLE) || (w_state_d == W_GOT_DATA);
            wready_q  <= (w_state_d == W_IDLE) || (w_state_d == W_GOT_ADDR);
            if (aw_hs) begin
                awaddr_q <= AWADDR;
                awid_q   <= AWID;
            end
            if (w_hs) begin
                wdata_q <= WDATA;
                wlast_q <= WLAST;
            end
            if (enter_resp) begin
                bvalid_q <= 1'b1;
                bid_q    <= eff_id;
                bresp_q  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else if (BREADY && bvalid_q) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_ok) begin
            mem_q[eff_addr[AW+1:2]] <= eff_data;
        end
    end

    // ---------------- read path ----------------
    logic [0:0]  r_state_q, r_state_d;
    logic        arready_q, rvalid_q, rlast_q;
    logic [31:0] rdata_q;
    logic [3:0]  rid_q;
    logic        ar_hs, r_hs;

    assign ar_hs = ARVALID && arready_q;
    assign r_hs  = RREADY && rvalid_q;

    always_comb begin
        r_state_d = r_state_q;
        case (r_state_q)
            R_IDLE:  if (ar_hs) r_state_d = R_DATA;
            R_DATA:  if (r_hs)  r_state_d = R_IDLE;
            default: r_state_d = R_IDLE;
        endcase
    end

    // mem_q is sampled before this edge's write lands, giving pre-write data on a collision.
    always_ff @(posedge ACLK or posedge ARESET) begin
        if (ARESET) begin
            r_state_q <= R_IDLE;
            arready_q <= 1'b0;
            rvalid_q  <= 1'b0;
            rlast_q   <= 1'b0;
            rdata_q   <= '0;
            rid_q     <= '0;
        end else begin
            r_state_q <= r_state_d;
            arready_q <= (r_state_d == R_IDLE);
            if (ar_hs) begin
                rdata_q  <= in_range(ARADDR) ? mem_q[ARADDR[AW+1:2]] : 32'h0;
                rid_q    <= ARID;
                rlast_q  <= 1'b1;
                rvalid_q <= 1'b1;
            end else if (r_hs) begin
                rvalid_q <= 1'b0;
                rlast_q  <= 1'b0;
            end
        end
    end

    assign AWREADY = awready_q;
    assign WREADY  = wready_q;
    assign BVALID  = bvalid_q;
    assign BRESP   = bresp_q;
    assign BID     = bid_q;
    assign ARREADY = arready_q;
    assign RVALID  = rvalid_q;
    assign RDATA   = rdata_q;
    assign RLAST   = rlast_q;
    assign RID     = rid_q;

endmodule

// File: tb/tb_axi_slave_mem.sv
// Directed bench for axi_slave_mem: reference memory model plus B/R response scoreboards.
module tb_axi_slave_mem;

    localparam int DEPTH = 16;

    logic        ACLK = 1'b0;
    logic        ARESET = 1'b1;
    logic        AWVALID = 1'b0, WVALID = 1'b0, BREADY = 1'b0, ARVALID = 1'b0, RREADY = 1'b0;
    logic [31:0] AWADDR = '0, WDATA = '0, ARADDR = '0;
    logic [3:0]  AWID = '0, ARID = '0;
    logic        WLAST = 1'b0;
    logic        AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST;
    logic [1:0]  BRESP;
    logic [3:0]  BID, RID;
    logic [31:0] RDATA;

    axi_slave_mem #(.DEPTH(DEPTH)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .AWVALID(AWVALID), .AWREADY(AWREADY), .AWADDR(AWADDR), .AWID(AWID),
        .WVALID(WVALID), .WREADY(WREADY), .WDATA(WDATA), .WLAST(WLAST),
        .BVALID(BVALID), .BREADY(BREADY), .BRESP(BRESP), .BID(BID),
        .ARVALID(ARVALID), .ARREADY(ARREADY), .ARADDR(ARADDR), .ARID(ARID),
        .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RLAST(RLAST), .RID(RID)
    );

    always #5 ACLK = ~ACLK;

    typedef struct packed { logic [3:0] id; logic [1:0] resp; } b_exp_t;
    typedef struct packed { logic [3:0] id; logic [31:0] data; } r_exp_t;

    b_exp_t      bq[$];
    r_exp_t      rq[$];
    logic [31:0] model [DEPTH];
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit addr_ok(input logic [31:0] a);
        return a < 32'(DEPTH * 4);
    endfunction

    function automatic r_exp_t read_exp(input logic [31:0] a, input logic [3:0] id);
        r_exp_t e;
        e.id   = id;
        e.data = addr_ok(a) ? model[a[31:2] % DEPTH] : 32'h0;
        return e;
    endfunction

    task automatic model_write(input logic [31:0] a, input logic [3:0] id, input logic [31:0] d,
                               input logic last);
        b_exp_t e;
        e.id   = id;
        e.resp = (addr_ok(a) && last) ? 2'b00 : 2'b10;
        if (addr_ok(a) && last) model[a[31:2] % DEPTH] = d;
        bq.push_back(e);
    endtask

    task automatic wait_wready(input string tag);
        for (int k = 0; k < 20 && !(AWREADY && WREADY); k++) @(negedge ACLK);
        chk(tag, {AWREADY, WREADY}, 2'b11);
    endtask

    task automatic wait_arready(input string tag);
        for (int k = 0; k < 20 && !ARREADY; k++) @(negedge ACLK);
        chk(tag, ARREADY, 1);
    endtask

    task automatic do_write(input logic [31:0] a, input logic [3:0] id, input logic [31:0] d,
                            input logic last);
        wait_wready("aw_w_ready");
        AWVALID = 1; AWADDR = a; AWID = id; WVALID = 1; WDATA = d; WLAST = last;
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0;
        chk("b_latency", BVALID, 1);
        model_write(a, id, d, last);
    endtask

    task automatic do_read(input logic [31:0] a, input logic [3:0] id);
        wait_arready("ar_ready");
        ARVALID = 1; ARADDR = a; ARID = id;
        @(negedge ACLK);
        ARVALID = 0;
        chk("r_latency", RVALID, 1);
        rq.push_back(read_exp(a, id));
    endtask

    task automatic collect_b();
        b_exp_t e;
        for (int k = 0; k < 20 && !BVALID; k++) @(negedge ACLK);
        chk("bvalid_wait", BVALID, 1);
        if (bq.size() == 0) begin
            chk("bq_nonempty", 0, 1);
        end else begin
            e = bq.pop_front();
            chk("bid", BID, e.id);
            chk("bresp", BRESP, e.resp);
        end
        BREADY = 1;
        @(negedge ACLK);
        BREADY = 0;
        chk("bvalid_clear", BVALID, 0);
    endtask

    task automatic collect_r();
        r_exp_t e;
        for (int k = 0; k < 20 && !RVALID; k++) @(negedge ACLK);
        chk("rvalid_wait", RVALID, 1);
        if (rq.size() == 0) begin
            chk("rq_nonempty", 0, 1);
        end else begin
            e = rq.pop_front();
            chk("rdata", RDATA, e.data);
            chk("rid", RID, e.id);
            chk("rlast", RLAST, 1);
        end
        RREADY = 1;
        @(negedge ACLK);
        RREADY = 0;
        chk("rvalid_clear", {RVALID, RLAST}, 2'b00);
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({AWREADY, WREADY, BVALID, BRESP, BID, ARREADY, RVALID, RDATA, RLAST, RID});
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < DEPTH; i++) model[i] = '0;

        // Reset state and ready release timing
        #1 chk("reset_outs", all_outs(), 0);
        @(negedge ACLK); @(negedge ACLK);
        ARESET = 0;
        #1 chk("ready_low_after_release", {AWREADY, WREADY, ARREADY}, 3'b000);
        @(negedge ACLK);
        chk("ready_high", {AWREADY, WREADY, ARREADY}, 3'b111);

        // Same-cycle write then read-back
        do_write(32'h8, 4'd3, 32'hDEADBEEF, 1'b1);
        collect_b();
        do_read(32'h8, 4'd5);
        collect_r();

        // Split write: W first, AW three cycles later
        wait_wready("split_ready");
        WVALID = 1; WDATA = 32'hA5A5_0001; WLAST = 1;
        @(negedge ACLK);
        WVALID = 0;
        for (int k = 0; k < 3; k++) begin
            chk("split_wready_low", WREADY, 0);
            chk("split_awready_high", AWREADY, 1);
            chk("split_no_bvalid", BVALID, 0);
            if (k < 2) @(negedge ACLK);
        end
        AWVALID = 1; AWADDR = 32'h1C; AWID = 4'd9;
        @(negedge ACLK);
        AWVALID = 0;
        chk("split_b_latency", BVALID, 1);
        model_write(32'h1C, 4'd9, 32'hA5A5_0001, 1'b1);
        collect_b();
        do_read(32'h1C, 4'd1);
        collect_r();

        // Error cases: out of range write/read, WLAST=0
        do_write(32'h100, 4'd7, 32'h1234_5678, 1'b1);
        collect_b();
        do_read(32'h100, 4'd2);
        collect_r();
        do_read(32'h0, 4'd2);
        collect_r();
        do_write(32'h8, 4'd4, 32'h0BAD_0BAD, 1'b0);
        collect_b();
        do_read(32'hB, 4'd6);
        collect_r();

        // Backpressure on B and R
        do_write(32'h10, 4'd12, 32'h5555_AAAA, 1'b1);
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            chk("bp_bvalid", BVALID, 1);
            chk("bp_bid", BID, bq[0].id);
            chk("bp_bresp", BRESP, bq[0].resp);
            chk("bp_w_readies", {AWREADY, WREADY}, 2'b00);
        end
        collect_b();
        do_read(32'h10, 4'd13);
        for (int k = 0; k < 5; k++) begin
            @(negedge ACLK);
            chk("bp_rvalid", RVALID, 1);
            chk("bp_rdata", RDATA, rq[0].data);
            chk("bp_arready", ARREADY, 0);
        end
        collect_r();

        // Simultaneous read and write of the same word returns the old value
        do_write(32'h4, 4'd1, 32'h11, 1'b1);
        collect_b();
        wait_wready("sim_w_ready");
        wait_arready("sim_ar_ready");
        AWVALID = 1; AWADDR = 32'h4; AWID = 4'd2; WVALID = 1; WDATA = 32'h22; WLAST = 1;
        ARVALID = 1; ARADDR = 32'h4; ARID = 4'd3;
        rq.push_back(read_exp(32'h4, 4'd3));
        @(negedge ACLK);
        AWVALID = 0; WVALID = 0; ARVALID = 0;
        model_write(32'h4, 4'd2, 32'h22, 1'b1);
        chk("sim_bvalid", BVALID, 1);
        chk("sim_rvalid", RVALID, 1);
        collect_b();
        collect_r();
        do_read(32'h4, 4'd4);
        collect_r();

        // Reset while a response is pending
        do_write(32'h30, 4'd8, 32'hCAFE_F00D, 1'b1);
        #2 ARESET = 1;
        #1 chk("midreset_outs", all_outs(), 0);
        bq.delete();
        rq.delete();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
        @(negedge ACLK); @(negedge ACLK);
        ARESET = 0;
        #1 chk("midreset_ready_low", {AWREADY, WREADY, ARREADY}, 3'b000);
        @(negedge ACLK);
        chk("midreset_ready_high", {AWREADY, WREADY, ARREADY}, 3'b111);
        chk("midreset_no_b", BVALID, 0);
        for (int i = 0; i < DEPTH; i++) begin
            do_read(32'(i * 4), 4'(i));
            collect_r();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/axi_slave_mem.md
AXI_SLAVE_MEM -- requirements
Module: axi_slave_mem

Interface
REQ-001 The block SHALL have one parameter, DEPTH, default 16, meaning the number of 32-bit memory words; it is a power of 2 in the range 2..256.
REQ-002 The block SHALL have port ACLK, input, 1 bit: the single clock; all state updates on the rising edge.
REQ-003 The block SHALL have port ARESET, input, 1 bit: the reset, asynchronous and active-high.
REQ-004 The block SHALL have the write address ports AWVALID (in, 1), AWREADY (out, 1), AWADDR (in, 32) and AWID (in, 4).
REQ-005 The block SHALL have the write data ports WVALID (in, 1), WREADY (out, 1), WDATA (in, 32) and WLAST (in, 1).
REQ-006 The block SHALL have the write response ports BVALID (out, 1), BREADY (in, 1), BRESP (out, 2) and BID (out, 4).
REQ-007 The block SHALL have the read address ports ARVALID (in, 1), ARREADY (out, 1), ARADDR (in, 32) and ARID (in, 4).
REQ-008 The block SHALL have the read data ports RVALID (out, 1), RREADY (in, 1), RDATA (out, 32), RLAST (out, 1) and RID (out, 4).
REQ-009 Every output SHALL be driven directly from a register, with no combinational path from any input to any output.

Function
REQ-010 A handshake SHALL occur on a channel at a rising ACLK edge where both VALID and READY are 1.
REQ-011 The word index SHALL be ADDR[log2(DEPTH)+1:2]; ADDR[1:0] is ignored.
REQ-012 An address is in range iff ADDR[31:log2(DEPTH)+2]==0; otherwise it is out of range.
REQ-013 The write FSM SHALL have four states: W_IDLE, W_GOT_ADDR, W_GOT_DATA and W_RESP.
REQ-014 AWREADY SHALL be 1 exactly when the write state is W_IDLE or W_GOT_DATA; WREADY SHALL be 1 exactly when the write state is W_IDLE or W_GOT_ADDR.
REQ-015 In W_IDLE, the write FSM SHALL move as follows:
- AW handshake only -> W_GOT_ADDR;
- W handshake only -> W_GOT_DATA;
- both AW and W handshakes on the same edge -> W_RESP.
REQ-016 From W_GOT_ADDR, a W handshake SHALL move the FSM to W_RESP; from W_GOT_DATA, an AW handshake SHALL move it to W_RESP.
REQ-017 AWADDR and AWID SHALL be captured at the AW handshake; WDATA and WLAST SHALL be captured at the W handshake.
REQ-018 On the edge entering W_RESP:
- the memory word is written only if the address is in range and WLAST==1;
- BID is set to the captured AWID;
- BRESP is set to 2'b00 (OKAY) if the write happened, else 2'b10 (SLVERR);
- BVALID is set to 1.
REQ-019 BVALID, BRESP and BID SHALL hold stable until the B handshake, after which BVALID=0 and the write FSM returns to W_IDLE.
REQ-020 Write latency SHALL be 1 cycle: with both AW and W handshakes at edge N, BVALID=1 after edge N.
REQ-021 The read FSM SHALL have two states: R_IDLE (ARREADY=1) and R_DATA (ARREADY=0, RVALID=1).
REQ-022 At the AR handshake, the read FSM SHALL:
- load RDATA with the memory word if in range, else 32'h0;
- load RID with ARID;
- set RLAST=1;
- move to R_DATA.
REQ-023 RDATA, RID and RLAST SHALL hold stable until the R handshake, after which RVALID=0, RLAST=0 and the read FSM returns to R_IDLE.
REQ-024 Read latency SHALL be 1 cycle from the AR handshake to RVALID=1.
REQ-025 The read and write FSMs SHALL be fully independent, with concurrent operation permitted.
REQ-026 If a read samples a word on the same edge that the word is written, the read SHALL return the pre-write value.
REQ-027 While BVALID=1 and BREADY=0, no further AW or W SHALL be accepted (both READYs 0); likewise, no AR SHALL be accepted while RVALID=1.

Reset
REQ-028 While ARESET=1, all outputs SHALL be 0, both FSMs SHALL be in IDLE, and all memory words SHALL be 0.
REQ-029 The ready outputs SHALL rise to 1 on the first ACLK edge with ARESET=0, so AWREADY, WREADY and ARREADY are 0 for at least one cycle after reset release.
REQ-030 Assertion of ARESET mid-transaction SHALL abort that transaction with no memory write and no response issued.

Verification
REQ-031 Same-cycle write: AW(addr 0x8, id 3) plus W(0xDEADBEEF, WLAST=1) on one edge -> next cycle BVALID=1, BRESP=00, BID=3; then a read of 0x8 with id 5 returns RDATA=0xDEADBEEF, RID=5, RLAST=1.
REQ-032 Split write: W first, then AW 3 cycles later -> WREADY=0 while waiting, BVALID one cycle after the AW handshake, and the memory updated.
REQ-033 Error cases:
- write to 0x100 with DEPTH=16 -> BRESP=10 and memory unchanged;
- read of 0x100 -> RDATA=0;
- write with WLAST=0 -> BRESP=10.
REQ-034 Backpressure: hold BREADY=0 for 5 cycles -> BVALID, BID and BRESP stable and AWREADY=WREADY=0; hold RREADY=0 likewise -> RDATA stable and ARREADY=0.
REQ-035 Simultaneous read and write of 0x4 (old value 0x11, new value 0x22) -> read returns 0x11, and a subsequent read returns 0x22.
REQ-036 Reset mid-operation: assert ARESET while BVALID=1 -> all outputs 0 immediately; after release, READYs are 0 for one cycle then 1, and all words read 0.
